// File: rtl/mc_core_v2_if.sv
// Memory-side bus of mc_core_v2: instruction fetch port and data port.
// The core is the master; memories/testbench sit on the slave side.
interface mc_core_v2_if #(
    parameter int IADDR_W = 10
);
    logic [IADDR_W-1:0] o_addr;
    logic [31:0]        odata;
    logic [31:0]        d_addr;
    logic [31:0]        wdata;
    logic               wea;
    logic [31:0]        rdata;

    modport master (
        output o_addr, d_addr, wdata, wea,
        input  odata, rdata
    );

    modport slave (
        input  o_addr, d_addr, wdata, wea,
        output odata, rdata
    );
endinterface

// File: rtl/mc_core_v2.sv
// Multi-cycle MIPS-subset core stepped by a clock-enable tick.
// FETCH -> EXEC -> WRITE/LOAD -> FETCH; an all-zero word halts.
module mc_core_v2 #(
    parameter int IADDR_W  = 10,
    parameter int DIV      = 1001,
    parameter int LOAD_LAT = 2,
    parameter int LED_REG  = 9
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                sw_c,
    mc_core_v2_if.master        bus,
    output logic [7:0]          led,
    output logic                halted
);
    localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int LCW = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
    localparam logic [DCW-1:0] DIV_MAX = DCW'(DIV - 1);
    localparam logic [LCW-1:0] LD_MAX  = LCW'(LOAD_LAT - 1);

    localparam logic [2:0] S_FETCH = 3'd0;
    localparam logic [2:0] S_EXEC  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_LOAD  = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    localparam logic [5:0] FN_JR  = 6'b001000;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    logic [DCW-1:0]     div_cnt;
    logic [LCW-1:0]     ld_cnt;
    logic               tick;
    logic [2:0]         state;
    logic [IADDR_W-1:0] pc;
    logic [31:0]        op;
    logic [31:0]        gpr [32];
    logic [31:0]        d_addr;
    logic [31:0]        wdata;
    logic               wea;

    logic [5:0]         opc;
    logic [5:0]         fn;
    logic [4:0]         rs_i;
    logic [4:0]         rt_i;
    logic [4:0]         rd_i;
    logic [31:0]        rs_v;
    logic [31:0]        rt_v;
    logic [31:0]        imm_s;
    logic [31:0]        ea;
    logic [IADDR_W-1:0] pc_inc;

    logic               wr_en;
    logic [4:0]         wr_idx;
    logic [31:0]        wr_val;
    logic [IADDR_W-1:0] pc_nxt;
    logic [2:0]         nxt;
    logic               is_lw;
    logic               is_sw;
    logic               unused_ok;

    assign tick   = (div_cnt == DIV_MAX);
    assign opc    = op[31:26];
    assign rs_i   = op[25:21];
    assign rt_i   = op[20:16];
    assign rd_i   = op[15:11];
    assign fn     = op[5:0];
    assign rs_v   = (rs_i == 5'd0) ? 32'd0 : gpr[rs_i];
    assign rt_v   = (rt_i == 5'd0) ? 32'd0 : gpr[rt_i];
    assign imm_s  = {{16{op[15]}}, op[15:0]};
    assign ea     = rs_v + imm_s;
    assign pc_inc = pc + 1'b1;

    assign bus.o_addr = pc;
    assign bus.d_addr = d_addr;
    assign bus.wdata  = wdata;
    assign bus.wea    = wea;
    assign led        = sw_c ? gpr[5'(LED_REG)][7:0] : 8'h00;
    assign halted     = (state == S_HALT);
    assign unused_ok  = ^op;

    always_comb begin
        wr_en  = 1'b0;
        wr_idx = rt_i;
        wr_val = 32'd0;
        pc_nxt = pc_inc;
        nxt    = S_WRITE;
        is_lw  = 1'b0;
        is_sw  = 1'b0;
        if (op == 32'd0) begin
            pc_nxt = pc;
            nxt    = S_HALT;
        end else begin
            unique case (1'b1)
                opc == OP_R: begin
                    wr_idx = rd_i;
                    wr_en  = 1'b1;
                    unique case (1'b1)
                        fn == FN_ADD: wr_val = rs_v + rt_v;
                        fn == FN_SUB: wr_val = rs_v - rt_v;
                        fn == FN_AND: wr_val = rs_v & rt_v;
                        fn == FN_OR:  wr_val = rs_v | rt_v;
                        fn == FN_SLT: wr_val = {31'd0, $signed(rs_v) < $signed(rt_v)};
                        fn == FN_JR: begin
                            wr_en  = 1'b0;
                            pc_nxt = rs_v[IADDR_W-1:0];
                        end
                        default: wr_en = 1'b0;
                    endcase
                end
                opc == OP_ADDI: begin
                    wr_en  = 1'b1;
                    wr_val = rs_v + imm_s;
                end
                opc == OP_SLTI: begin
                    wr_en  = 1'b1;
                    wr_val = {31'd0, $signed(rs_v) < $signed(imm_s)};
                end
                opc == OP_BEQ: begin
                    if (rs_v == rt_v) pc_nxt = pc_inc + imm_s[IADDR_W-1:0];
                end
                opc == OP_BNE: begin
                    if (rs_v != rt_v) pc_nxt = pc_inc + imm_s[IADDR_W-1:0];
                end
                opc == OP_J: pc_nxt = op[IADDR_W-1:0];
                opc == OP_JAL: begin
                    pc_nxt = op[IADDR_W-1:0];
                    wr_en  = 1'b1;
                    wr_idx = 5'd31;
                    wr_val = 32'(pc_inc);
                end
                opc == OP_LW: begin
                    is_lw = 1'b1;
                    nxt   = S_LOAD;
                end
                opc == OP_SW: is_sw = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            div_cnt <= '0;
            ld_cnt  <= '0;
            state   <= S_FETCH;
            pc      <= '0;
            op      <= 32'd0;
            d_addr  <= 32'd0;
            wdata   <= 32'd0;
            wea     <= 1'b0;
            for (int i = 0; i < 32; i++) gpr[i] <= 32'd0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
                unique case (state)
                    S_FETCH: begin
                        op    <= bus.odata;
                        state <= S_EXEC;
                    end
                    S_EXEC: begin
                        pc    <= pc_nxt;
                        state <= nxt;
                        if (wr_en && wr_idx != 5'd0) gpr[wr_idx] <= wr_val;
                        if (is_lw || is_sw) d_addr <= ea;
                        if (is_sw) begin
                            wdata <= rt_v;
                            wea   <= 1'b1;
                        end
                    end
                    S_WRITE: begin
                        wea   <= 1'b0;
                        state <= S_FETCH;
                    end
                    S_LOAD: begin
                        if (ld_cnt == LD_MAX) begin
                            ld_cnt <= '0;
                            state  <= S_FETCH;
                            if (rt_i != 5'd0) gpr[rt_i] <= bus.rdata;
                        end else begin
                            ld_cnt <= ld_cnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mc_core_v2.sv
// Bench for mc_core_v2: two instances (fast tick / slow tick, narrow pc)
// with store transactions checked through an expected-value queue.
module tb_mc_core_v2;
    localparam int DIV_A = 1;
    localparam int DIV_B = 4;

    localparam logic [5:0] J    = 6'b000010;
    localparam logic [5:0] JAL  = 6'b000011;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] BNE  = 6'b000101;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] SLTI = 6'b001010;
    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] F_JR  = 6'b001000;
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [31:0] NOP = 32'hFC00_0000;

    logic clk = 1'b0;
    logic rstn_a = 1'b0;
    logic rstn_b = 1'b0;
    logic sw_a = 1'b0;
    logic sw_b = 1'b0;
    logic [31:0] rdata_a = 32'd0;
    logic [7:0] led_a;
    logic [7:0] led_b;
    logic halted_a;
    logic halted_b;
    logic [31:0] imem_a [1024];
    logic [31:0] imem_b [16];
    logic [63:0] exp_a [$];
    logic [63:0] exp_b [$];
    logic [63:0] e_a;
    logic [63:0] e_b;
    logic wea_a_q = 1'b0;
    logic wea_b_q = 1'b0;
    int hi_a = 0;
    int hi_b = 0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mc_core_v2_if #(.IADDR_W(10)) bus_a ();
    mc_core_v2_if #(.IADDR_W(4))  bus_b ();

    assign bus_a.odata = imem_a[bus_a.o_addr];
    assign bus_a.rdata = rdata_a;
    assign bus_b.odata = imem_b[bus_b.o_addr];
    assign bus_b.rdata = 32'hBAD0_0000;

    mc_core_v2 #(.IADDR_W(10), .DIV(DIV_A), .LOAD_LAT(3), .LED_REG(9)) dut_a (
        .clk(clk), .rstn(rstn_a), .sw_c(sw_a), .bus(bus_a),
        .led(led_a), .halted(halted_a)
    );

    mc_core_v2 #(.IADDR_W(4), .DIV(DIV_B), .LOAD_LAT(2), .LED_REG(9)) dut_b (
        .clk(clk), .rstn(rstn_b), .sw_c(sw_b), .bus(bus_b),
        .led(led_b), .halted(halted_b)
    );

    function automatic logic [31:0] it(logic [5:0] o, logic [4:0] s, logic [4:0] t, logic [15:0] imm);
        return {o, s, t, imm};
    endfunction

    function automatic logic [31:0] rt(logic [4:0] s, logic [4:0] t, logic [4:0] d, logic [5:0] f);
        return {6'd0, s, t, d, 5'd0, f};
    endfunction

    // Store monitors: pop expected {d_addr,wdata} on each wea rise, check pulse length.
    always @(negedge clk) begin
        if (bus_a.wea && !wea_a_q) begin
            total++;
            if (exp_a.size() == 0) begin
                bad++;
                $display("FAIL sb_a_extra got=%h/%h exp=none", bus_a.d_addr, bus_a.wdata);
            end else begin
                e_a = exp_a.pop_front();
                if ({bus_a.d_addr, bus_a.wdata} !== e_a) begin
                    bad++;
                    $display("FAIL sb_a_store got=%h/%h exp=%h/%h", bus_a.d_addr, bus_a.wdata, e_a[63:32], e_a[31:0]);
                end
            end
        end
        if (!bus_a.wea && wea_a_q && rstn_a) begin
            total++;
            if (hi_a !== DIV_A) begin
                bad++;
                $display("FAIL wea_a_width got=%0d exp=%0d", hi_a, DIV_A);
            end
        end
        hi_a <= bus_a.wea ? hi_a + 1 : 0;
        wea_a_q <= bus_a.wea;
    end

    always @(negedge clk) begin
        if (bus_b.wea && !wea_b_q) begin
            total++;
            if (exp_b.size() == 0) begin
                bad++;
                $display("FAIL sb_b_extra got=%h/%h exp=none", bus_b.d_addr, bus_b.wdata);
            end else begin
                e_b = exp_b.pop_front();
                if ({bus_b.d_addr, bus_b.wdata} !== e_b) begin
                    bad++;
                    $display("FAIL sb_b_store got=%h/%h exp=%h/%h", bus_b.d_addr, bus_b.wdata, e_b[63:32], e_b[31:0]);
                end
            end
        end
        if (!bus_b.wea && wea_b_q && rstn_b) begin
            total++;
            if (hi_b !== DIV_B) begin
                bad++;
                $display("FAIL wea_b_width got=%0d exp=%0d", hi_b, DIV_B);
            end
        end
        hi_b <= bus_b.wea ? hi_b + 1 : 0;
        wea_b_q <= bus_b.wea;
    end

    task automatic hold_a();
        rstn_a = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 1024; i++) imem_a[i] = 32'd0;
    endtask

    task automatic go_a();
        @(negedge clk);
        rstn_a = 1'b1;
    endtask

    task automatic hold_b();
        rstn_b = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 16; i++) imem_b[i] = 32'd0;
    endtask

    task automatic go_b();
        @(negedge clk);
        rstn_b = 1'b1;
    endtask

    task automatic tick_a(int n);
        repeat (n * DIV_A) @(negedge clk);
    endtask

    task automatic tick_b(int n);
        repeat (n * DIV_B) @(negedge clk);
    endtask

    task automatic test_reset();
        sw_a = 1'b1;
        sw_b = 1'b1;
        hold_a();
        hold_b();
        @(negedge clk);
        total += 7;
        if (bus_a.o_addr !== 10'd0) begin bad++; $display("FAIL rst_pc_a got=%h exp=0", bus_a.o_addr); end
        if (bus_a.d_addr !== 32'd0) begin bad++; $display("FAIL rst_daddr got=%h exp=0", bus_a.d_addr); end
        if (bus_a.wdata !== 32'd0) begin bad++; $display("FAIL rst_wdata got=%h exp=0", bus_a.wdata); end
        if (bus_a.wea !== 1'b0) begin bad++; $display("FAIL rst_wea got=%b exp=0", bus_a.wea); end
        if (halted_a !== 1'b0) begin bad++; $display("FAIL rst_halted got=%b exp=0", halted_a); end
        if (led_a !== 8'h00) begin bad++; $display("FAIL rst_led got=%h exp=0", led_a); end
        if (bus_b.o_addr !== 4'd0) begin bad++; $display("FAIL rst_pc_b got=%h exp=0", bus_b.o_addr); end
    endtask

    task automatic test_led_halt();
        hold_a();
        imem_a[0] = it(ADDI, 5'd0, 5'd9, 16'h005A);
        sw_a = 1'b1;
        go_a();
        tick_a(3);
        total += 4;
        if (led_a !== 8'h5A) begin bad++; $display("FAIL led_val got=%h exp=5a", led_a); end
        tick_a(1);
        if (halted_a !== 1'b0) begin bad++; $display("FAIL halt_early got=%b exp=0", halted_a); end
        tick_a(2);
        if (halted_a !== 1'b1) begin bad++; $display("FAIL halt_set got=%b exp=1", halted_a); end
        sw_a = 1'b0;
        #1;
        if (led_a !== 8'h00) begin bad++; $display("FAIL led_off got=%h exp=0", led_a); end
        sw_a = 1'b1;
        tick_a(5);
        total += 2;
        if (bus_a.o_addr !== 10'd1) begin bad++; $display("FAIL halt_pc got=%h exp=1", bus_a.o_addr); end
        if (halted_a !== 1'b1) begin bad++; $display("FAIL halt_hold got=%b exp=1", halted_a); end
    endtask

    task automatic test_tick();
        hold_b();
        imem_b[0] = it(ADDI, 5'd0, 5'd9, 16'h0033);
        go_b();
        repeat (3) @(negedge clk);
        total += 5;
        if (bus_b.o_addr !== 4'd0) begin bad++; $display("FAIL tick_pc3 got=%h exp=0", bus_b.o_addr); end
        repeat (4) @(negedge clk);
        if (led_b !== 8'h00) begin bad++; $display("FAIL tick_led7 got=%h exp=0", led_b); end
        if (bus_b.o_addr !== 4'd0) begin bad++; $display("FAIL tick_pc7 got=%h exp=0", bus_b.o_addr); end
        @(negedge clk);
        if (led_b !== 8'h33) begin bad++; $display("FAIL tick_led8 got=%h exp=33", led_b); end
        if (bus_b.o_addr !== 4'd1) begin bad++; $display("FAIL tick_pc8 got=%h exp=1", bus_b.o_addr); end
    endtask

    task automatic test_alu();
        int a = -5;
        int b = 7;
        int idx [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 10, 11, 12, 0};
        logic [31:0] ex [12];
        ex = '{32'(a), 32'(b), 32'(a + b), 32'(a - b), 32'(a & b), 32'(a | b),
               32'(a < b), 32'(b < a), 32'(a < -4), 32'(b < 7), 32'(0 - b), 32'd0};
        hold_a();
        imem_a[0]  = it(ADDI, 5'd0, 5'd1, 16'hFFFB);
        imem_a[1]  = it(ADDI, 5'd0, 5'd2, 16'd7);
        imem_a[2]  = rt(5'd1, 5'd2, 5'd3, F_ADD);
        imem_a[3]  = rt(5'd1, 5'd2, 5'd4, F_SUB);
        imem_a[4]  = rt(5'd1, 5'd2, 5'd5, F_AND);
        imem_a[5]  = rt(5'd1, 5'd2, 5'd6, F_OR);
        imem_a[6]  = rt(5'd1, 5'd2, 5'd7, F_SLT);
        imem_a[7]  = rt(5'd2, 5'd1, 5'd8, F_SLT);
        imem_a[8]  = it(SLTI, 5'd1, 5'd10, 16'hFFFC);
        imem_a[9]  = it(SLTI, 5'd2, 5'd11, 16'd7);
        imem_a[10] = rt(5'd0, 5'd2, 5'd12, F_SUB);
        imem_a[11] = it(ADDI, 5'd0, 5'd0, 16'd7);
        go_a();
        tick_a(36);
        for (int i = 0; i < 12; i++) begin
            total++;
            if (dut_a.gpr[idx[i]] !== ex[i]) begin
                bad++;
                $display("FAIL alu_r%0d got=%h exp=%h", idx[i], dut_a.gpr[idx[i]], ex[i]);
            end
        end
    endtask

    task automatic test_load();
        hold_a();
        imem_a[0] = it(LW, 5'd0, 5'd2, 16'd4);
        rdata_a = 32'hDEAD_BEEF;
        go_a();
        tick_a(2);
        total += 5;
        if (bus_a.d_addr !== 32'd4) begin bad++; $display("FAIL lw_addr got=%h exp=4", bus_a.d_addr); end
        tick_a(2);
        if (dut_a.gpr[2] !== 32'd0) begin bad++; $display("FAIL lw_early got=%h exp=0", dut_a.gpr[2]); end
        tick_a(1);
        if (dut_a.gpr[2] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL lw_data got=%h exp=deadbeef", dut_a.gpr[2]); end
        if (bus_a.o_addr !== 10'd1) begin bad++; $display("FAIL lw_pc got=%h exp=1", bus_a.o_addr); end
        if (halted_a !== 1'b0) begin bad++; $display("FAIL lw_nohalt got=%b exp=0", halted_a); end
        hold_a();
        imem_a[0] = it(LW, 5'd0, 5'd2, 16'd4);
        go_a();
        tick_a(3);
        rstn_a = 1'b0;
        @(negedge clk);
        total += 2;
        if (dut_a.gpr[2] !== 32'd0) begin bad++; $display("FAIL lw_abort_r2 got=%h exp=0", dut_a.gpr[2]); end
        if (bus_a.o_addr !== 10'd0) begin bad++; $display("FAIL lw_abort_pc got=%h exp=0", bus_a.o_addr); end
        rstn_a = 1'b1;
        tick_a(4);
        total += 2;
        if (dut_a.gpr[2] !== 32'd0) begin bad++; $display("FAIL lw_rerun_early got=%h exp=0", dut_a.gpr[2]); end
        tick_a(1);
        if (dut_a.gpr[2] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL lw_rerun got=%h exp=deadbeef", dut_a.gpr[2]); end
    endtask

    task automatic drain(bit which, int budget);
        int n = 0;
        while ((which ? exp_b.size() : exp_a.size()) != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        if ((which ? exp_b.size() : exp_a.size()) != 0) begin
            bad++;
            $display("FAIL drain_%0d got=%0d pending exp=0", which, which ? exp_b.size() : exp_a.size());
        end
    endtask

    task automatic test_store();
        hold_a();
        imem_a[0] = it(ADDI, 5'd0, 5'd1, 16'h1234);
        imem_a[1] = it(SW, 5'd0, 5'd1, 16'd8);
        imem_a[2] = it(ADDI, 5'd0, 5'd3, 16'h0055);
        imem_a[3] = it(SW, 5'd1, 5'd3, 16'd12);
        exp_a.push_back({32'd8, 32'h1234});
        exp_a.push_back({32'h1240, 32'h55});
        go_a();
        drain(1'b0, 60);
        tick_a(3);
        hold_b();
        imem_b[0] = it(ADDI, 5'd0, 5'd1, 16'h1234);
        imem_b[1] = it(SW, 5'd0, 5'd1, 16'd8);
        exp_b.push_back({32'd8, 32'h1234});
        go_b();
        drain(1'b1, 100);
        tick_b(3);
    endtask

    task automatic test_reset_write();
        hold_b();
        imem_b[0] = it(ADDI, 5'd0, 5'd1, 16'h1234);
        imem_b[1] = it(SW, 5'd0, 5'd1, 16'd8);
        exp_b.push_back({32'd8, 32'h1234});
        go_b();
        repeat (21) @(negedge clk);
        total += 3;
        if (bus_b.wea !== 1'b1) begin bad++; $display("FAIL rw_wea_hi got=%b exp=1", bus_b.wea); end
        rstn_b = 1'b0;
        @(negedge clk);
        if (bus_b.wea !== 1'b0) begin bad++; $display("FAIL rw_wea_drop got=%b exp=0", bus_b.wea); end
        if (bus_b.d_addr !== 32'd0) begin bad++; $display("FAIL rw_daddr got=%h exp=0", bus_b.d_addr); end
        drain(1'b1, 4);
    endtask

    task automatic test_branch();
        hold_a();
        for (int i = 0; i < 5; i++) imem_a[i] = NOP;
        imem_a[5] = it(BEQ, 5'd0, 5'd0, 16'hFFFF);
        go_a();
        tick_a(17);
        total += 2;
        if (bus_a.o_addr !== 10'd5) begin bad++; $display("FAIL beq_self got=%h exp=5", bus_a.o_addr); end
        tick_a(6);
        if (bus_a.o_addr !== 10'd5) begin bad++; $display("FAIL beq_loop got=%h exp=5", bus_a.o_addr); end
        hold_a();
        for (int i = 0; i < 5; i++) imem_a[i] = NOP;
        imem_a[5] = it(BNE, 5'd0, 5'd0, 16'd7);
        go_a();
        tick_a(17);
        total++;
        if (bus_a.o_addr !== 10'd6) begin bad++; $display("FAIL bne_nt got=%h exp=6", bus_a.o_addr); end
        hold_a();
        imem_a[0] = it(ADDI, 5'd0, 5'd1, 16'd1);
        imem_a[1] = it(BNE, 5'd1, 5'd0, 16'd3);
        go_a();
        tick_a(5);
        total++;
        if (bus_a.o_addr !== 10'd5) begin bad++; $display("FAIL bne_tk got=%h exp=5", bus_a.o_addr); end
    endtask

    task automatic test_jump();
        hold_a();
        for (int i = 0; i < 3; i++) imem_a[i] = NOP;
        imem_a[3]  = {JAL, 26'h10};
        imem_a[16] = rt(5'd31, 5'd0, 5'd0, F_JR);
        imem_a[4]  = it(ADDI, 5'd0, 5'd0, 16'd7);
        go_a();
        tick_a(11);
        total += 5;
        if (bus_a.o_addr !== 10'h10) begin bad++; $display("FAIL jal_pc got=%h exp=10", bus_a.o_addr); end
        if (dut_a.gpr[31] !== 32'd4) begin bad++; $display("FAIL jal_ra got=%h exp=4", dut_a.gpr[31]); end
        tick_a(3);
        if (bus_a.o_addr !== 10'd4) begin bad++; $display("FAIL jr_pc got=%h exp=4", bus_a.o_addr); end
        tick_a(3);
        if (dut_a.gpr[0] !== 32'd0) begin bad++; $display("FAIL r0_zero got=%h exp=0", dut_a.gpr[0]); end
        tick_a(3);
        if (halted_a !== 1'b1) begin bad++; $display("FAIL jmp_halt got=%b exp=1", halted_a); end
        hold_b();
        imem_b[0]  = {J, 26'd15};
        imem_b[15] = NOP;
        go_b();
        tick_b(2);
        total += 2;
        if (bus_b.o_addr !== 4'd15) begin bad++; $display("FAIL j15 got=%h exp=f", bus_b.o_addr); end
        tick_b(3);
        if (bus_b.o_addr !== 4'd0) begin bad++; $display("FAIL pc_wrap got=%h exp=0", bus_b.o_addr); end
    endtask

    initial begin
        test_reset();
        test_led_halt();
        test_tick();
        test_alu();
        test_load();
        test_store();
        test_reset_write();
        test_branch();
        test_jump();
        total += 2;
        if (exp_a.size() != 0) begin bad++; $display("FAIL sb_a_left got=%0d exp=0", exp_a.size()); end
        if (exp_b.size() != 0) begin bad++; $display("FAIL sb_b_left got=%0d exp=0", exp_b.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mc_core_v2.md
MC_CORE_V2 -- requirements
Module: mc_core_v2

Interface
REQ-001 Parameter IADDR_W, default 10, instruction word-address width; pc width.
REQ-002 Parameter DIV, default 1001, clock-enable divide ratio, >=1; 1 = step every clk.
REQ-003 Parameter LOAD_LAT, default 2, ticks waited in LOAD before rdata capture, >=1.
REQ-004 Parameter LED_REG, default 9, GPR index driven to led.
REQ-005 clk  in  1  single clock; all state changes on posedge clk.
REQ-006 rstn  in  1  reset, synchronous, active-low.
REQ-007 sw_c  in  1  led enable.
REQ-008 odata  in  32  instruction word at o_addr.
REQ-009 rdata  in  32  data-memory read data.
REQ-010 o_addr  out  IADDR_W  instruction address; combinationally equals pc.
REQ-011 d_addr  out  32  data-memory address, registered.
REQ-012 wdata  out  32  store data, registered.
REQ-013 wea  out  1  data-memory write enable, registered.
REQ-014 led  out  8  sw_c ? GPR[LED_REG][7:0] : 8'h00, combinational.
REQ-015 halted  out  1  high while FSM is in HALT.

Function
REQ-016 Tick: divider counter 0..DIV-1; tick high for one clk when counter==DIV-1, then counter wraps to 0; FSM changes state only on tick cycles.
REQ-017 States FETCH, EXEC, WRITE, LOAD, HALT; all transitions below occur on tick only.
REQ-018 FETCH: op <= odata; -> EXEC.
REQ-019 EXEC: execute op per REQ-020..REQ-027; -> WRITE, except LW -> LOAD and op==32'h0 -> HALT.
REQ-020 R-type (op[31:26]=0), rd=op[15:11]: ADD 100000, SUB 100010 (32-bit wrap, no overflow trap), AND 100100, OR 100101, SLT 101010 (signed, result 1/0); JR 001000: pc <= rs[IADDR_W-1:0], no GPR write.
REQ-021 ADDI 001000: rt <= rs + sext(imm16); SLTI 001010: rt <= (signed rs < sext(imm16)) ? 1 : 0.
REQ-022 BEQ 000100 / BNE 000101: if taken, pc <= pc + 1 + sext(imm16) truncated to IADDR_W; else pc <= pc + 1.
REQ-023 J 000010: pc <= op[IADDR_W-1:0]; JAL 000011: same, plus GPR31 <= zero-extended pc + 1.
REQ-024 LW 100011: d_addr <= rs + sext(imm16); pc <= pc + 1; -> LOAD.
REQ-025 SW 101011: d_addr <= rs + sext(imm16); wdata <= rt; wea <= 1; pc <= pc + 1.
REQ-026 Any other encoding: NOP, pc <= pc + 1.
REQ-027 pc arithmetic modulo 2^IADDR_W; increment from all-ones wraps to 0.
REQ-028 GPR0 reads 0 always; writes to GPR0 discarded.
REQ-029 WRITE: wea <= 0; -> FETCH; wea therefore high exactly one tick period per SW.
REQ-030 LOAD: wait counter counts ticks; on LOAD_LAT-th tick in LOAD, rt <= rdata, -> FETCH.
REQ-031 Cycle cost in ticks: LW 2+LOAD_LAT; all others 3; HALT terminal until reset.
REQ-032 HALT: pc, GPRs, d_addr, wdata frozen; wea 0; halted 1.

Reset
REQ-033 rstn low at posedge clk: pc=0, state FETCH, divider and load counters 0, op=0, all GPRs 0, d_addr=0, wdata=0, wea=0, halted=0.
REQ-034 Reset overrides tick and all state activity on the same edge; reset in LOAD aborts load with no GPR write; reset in WRITE drops wea immediately on that edge.

Verification
REQ-035 DIV=1, program ADDI r9,r0,0x5A; halt word; sw_c=1 -> led=0x5A after 3 ticks, halted=1 at tick 6, led=0 when sw_c=0.
REQ-036 DIV=4, single ADDI -> EXEC result visible exactly 8 clks after rstn release; no state change on non-tick clks.
REQ-037 LOAD_LAT=3, LW r2,4(r0), rdata=0xDEADBEEF -> d_addr=4, r2=0xDEADBEEF after 5 ticks; reset asserted mid-LOAD -> r2 stays 0, pc=0.
REQ-038 SW r1,8(r0) with r1=0x1234 -> wea high exactly one tick, d_addr=8, wdata=0x1234.
REQ-039 BEQ taken with imm=-1 at pc=5 -> pc=5; BNE not taken -> pc=6; IADDR_W=4, J 15 then NOP -> pc wraps to 0.
REQ-040 JAL 0x10 at pc=3 -> GPR31=4, pc=0x10; JR r31 -> pc=4; ADDI r0,r0,7 -> GPR0 reads 0.
